// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbiter state encoding, bus widths, WE_READ byte-enable value,
//           packed memory command latched on every grant.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Byte enables of a read access (instruction fetches are always reads).
  localparam logic [BE_W-1:0] WE_READ = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } arb_state_e;

  // Everything driven onto the memory bus for one access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of core-side (fetch + data) and memory-side signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: blocking_n level stalls towards the core; mem_ready_i completes memory access.
// Modports: master = arbiter view (drives *_o), slave = core + memory view (drives *_i).
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              instr_blocking_n_o;

  logic              data_req_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [BE_W-1:0]   data_we_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_blocking_n_o;

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BE_W-1:0]   mem_we_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              bus_err_o;

  modport master (
    input  instr_req_i, instr_addr_i,
    output instr_rdata_o, instr_blocking_n_o,
    input  data_req_i, data_addr_i, data_we_i, data_wdata_i,
    output data_rdata_o, data_blocking_n_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i,
    output bus_err_o
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    input  instr_rdata_o, instr_blocking_n_o,
    output data_req_i, data_addr_i, data_we_i, data_wdata_i,
    input  data_rdata_o, data_blocking_n_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i,
    input  bus_err_o
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Counts cycles of an outstanding memory access and flags the last allowed one.
// Latency: expire_o is combinational on the count; count updates each clock.
// Backpressure: none; clr_i has priority over en_i.
// Ports: clk_i/rst_i clock and async reset, clr_i restart, en_i count, expire_o final cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // The count equals the number of enabled cycles already completed, so
  // expiry fires during the TIMEOUT_CYCLES-th enabled cycle. Holds at LAST.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data port.
// Latency: request in IDLE at cycle 0 -> mem_req_o at 1; ready at N -> blocking_n high at N+1.
// Backpressure: per-side blocking_n stalls the core; mem_ready_i ends an access, timeout aborts it.
// Ports: clk_i, rst_i (async active-high); bus (master modport) carries fetch, data and memory
//        signals plus the sticky bus_err_o timeout flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.master bus
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  arb_state_e        state_q;
  mem_cmd_t          cmd_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] instr_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              bus_err_q;
  logic [SW-1:0]     streak_q, streak_d;

  logic grant_d, grant_i;
  logic busy;
  logic timeout_exp;

  // Data wins unless the fetch has already waited out MAX_DATA_STREAK data grants.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.data_req_i && !(bus.instr_req_i && streak_q == STREAK_MAX)) begin
        grant_d = 1'b1;
      end else if (bus.instr_req_i) begin
        grant_i = 1'b1;
      end
    end
  end

  // Streak only measures data grants that overtook a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (!bus.instr_req_i || grant_i) begin
      streak_d = '0;
    end else if (grant_d && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  assign busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (!busy),
    .en_i    (busy),
    .expire_o(timeout_exp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      mem_req_q     <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      bus_err_q     <= 1'b0;
      streak_q      <= '0;
    end else begin
      streak_q <= streak_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            state_q   <= ST_BUSY_D;
            cmd_q     <= '{addr: bus.data_addr_i, we: bus.data_we_i, wdata: bus.data_wdata_i};
            mem_req_q <= 1'b1;
          end else if (grant_i) begin
            state_q   <= ST_BUSY_I;
            cmd_q     <= '{addr: bus.instr_addr_i, we: WE_READ, wdata: '0};
            mem_req_q <= 1'b1;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // A fetch completes even if the core redirected meanwhile; the
          // address compare on instr_blocking_n_o drops the stale word.
          if (bus.mem_ready_i) begin
            if (state_q == ST_BUSY_I) instr_rdata_q <= bus.mem_rdata_i;
            else                      data_rdata_q  <= bus.mem_rdata_i;
            mem_req_q <= 1'b0;
            state_q   <= (state_q == ST_BUSY_I) ? ST_DONE_I : ST_DONE_D;
          end else if (timeout_exp) begin
            if (state_q == ST_BUSY_I) instr_rdata_q <= '0;
            else                      data_rdata_q  <= '0;
            bus_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= (state_q == ST_BUSY_I) ? ST_DONE_I : ST_DONE_D;
          end
        end
        ST_DONE_I, ST_DONE_D: state_q <= ST_IDLE;
        default:              state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_addr_o  = cmd_q.addr;
  assign bus.mem_we_o    = cmd_q.we;
  assign bus.mem_wdata_o = cmd_q.wdata;
  assign bus.bus_err_o   = bus_err_q;

  assign bus.instr_rdata_o = instr_rdata_q;
  assign bus.data_rdata_o  = data_rdata_q;

  assign bus.instr_blocking_n_o = !bus.instr_req_i ||
                                  (state_q == ST_DONE_I && bus.instr_addr_i == cmd_q.addr);
  assign bus.data_blocking_n_o  = !bus.data_req_i || (state_q == ST_DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios, a memory responder, a
// transaction-level reference model checked every cycle, and literal spot checks.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXS = 2;
  localparam int TMO  = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MAX_DATA_STREAK(MAXS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'h040) return 32'hCAFEBABE;
    return {2'b00, a} ^ 32'h5A5A5A5A;
  endfunction

  // Memory responder: ready arrives in the mem_lat-th cycle of a request
  // (mem_lat = 0 means never); force_ready injects a stray ready pulse.
  int mem_lat     = 0;
  bit force_ready = 1'b0;
  int req_age     = 0;
  always @(posedge clk_i) begin
    #1;
    if (bus.mem_req_o) req_age++;
    else               req_age = 0;
    bus.mem_ready_i = force_ready || (bus.mem_req_o && mem_lat != 0 && req_age == mem_lat);
    bus.mem_rdata_i = bus.mem_ready_i ? mem_word(bus.mem_addr_o) : 32'hDEADBEEF;
  end

  // Reference model: one outstanding transaction with an age in cycles,
  // plus a one-cycle completion marker and a streak count of overtaking data grants.
  bit          m_req = 0, m_done = 0, m_is_data = 0, m_err = 0;
  int          m_age = 0, m_streak = 0;
  logic [29:0] m_addr = '0;
  logic [3:0]  m_we = '0;
  logic [31:0] m_wdata = '0, m_ir = '0, m_dr = '0;

  always @(posedge clk_i or posedge rst_i) begin : model
    bit gi, gd;
    gi = 0;
    gd = 0;
    if (rst_i) begin
      m_req = 0; m_done = 0; m_is_data = 0; m_err = 0; m_age = 0; m_streak = 0;
      m_addr = '0; m_we = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
    end else begin
      if (m_done) begin
        m_done = 0;
      end else if (m_req) begin
        m_age++;
        if (bus.mem_ready_i) begin
          if (m_is_data) m_dr = bus.mem_rdata_i;
          else           m_ir = bus.mem_rdata_i;
          m_req = 0;
          m_done = 1;
        end else if (m_age >= TMO) begin
          if (m_is_data) m_dr = '0;
          else           m_ir = '0;
          m_err = 1;
          m_req = 0;
          m_done = 1;
        end
      end else begin
        if (bus.data_req_i && !(bus.instr_req_i && m_streak == MAXS)) gd = 1;
        else if (bus.instr_req_i) gi = 1;
        if (gd) begin
          m_is_data = 1; m_addr = bus.data_addr_i; m_we = bus.data_we_i;
          m_wdata = bus.data_wdata_i; m_req = 1; m_age = 0;
        end
        if (gi) begin
          m_is_data = 0; m_addr = bus.instr_addr_i; m_we = 4'b0000;
          m_wdata = '0; m_req = 1; m_age = 0;
        end
      end
      if (!bus.instr_req_i || gi) m_streak = 0;
      else if (gd)                m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
    end
  end

  always @(negedge clk_i) begin
    check("mdl_mem_req",   {31'd0, bus.mem_req_o}, {31'd0, m_req});
    check("mdl_mem_addr",  {2'b00, bus.mem_addr_o}, {2'b00, m_addr});
    check("mdl_mem_we",    {28'd0, bus.mem_we_o}, {28'd0, m_we});
    check("mdl_mem_wdata", bus.mem_wdata_o, m_wdata);
    check("mdl_instr_bn",  {31'd0, bus.instr_blocking_n_o},
          {31'd0, (!bus.instr_req_i || (m_done && !m_is_data && bus.instr_addr_i == m_addr))});
    check("mdl_data_bn",   {31'd0, bus.data_blocking_n_o},
          {31'd0, (!bus.data_req_i || (m_done && m_is_data))});
    check("mdl_instr_rd",  bus.instr_rdata_o, m_ir);
    check("mdl_data_rd",   bus.data_rdata_o, m_dr);
    check("mdl_bus_err",   {31'd0, bus.bus_err_o}, {31'd0, m_err});
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_we_i    = 4'b0000;
    bus.data_wdata_i = '0;

    tick();
    check("rst_mem_req",  {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_mem_addr", {2'b00, bus.mem_addr_o}, 32'd0);
    check("rst_bus_err",  {31'd0, bus.bus_err_o}, 32'd0);
    check("rst_data_rd",  bus.data_rdata_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // 1: lone data read, ready in cycle 3
    mem_lat = 3;
    bus.data_req_i = 1'b1; bus.data_addr_i = 30'h040; bus.data_we_i = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t1_req_busy", {31'd0, bus.mem_req_o}, 32'd1);
      check("t1_addr",     {2'b00, bus.mem_addr_o}, 32'h040);
      check("t1_bn_low",   {31'd0, bus.data_blocking_n_o}, 32'd0);
    end
    tick();
    check("t1_req_done", {31'd0, bus.mem_req_o}, 32'd0);
    check("t1_bn_high",  {31'd0, bus.data_blocking_n_o}, 32'd1);
    check("t1_rdata",    bus.data_rdata_o, 32'hCAFEBABE);
    bus.data_req_i = 1'b0;
    tick();

    // 2: simultaneous fetch and store, data first
    mem_lat = 2;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 30'h080;
    bus.data_req_i = 1'b1; bus.data_addr_i = 30'h044;
    bus.data_we_i = 4'b1111; bus.data_wdata_i = 32'h12345678;
    tick();
    check("t2_we",    {28'd0, bus.mem_we_o}, 32'hF);
    check("t2_addr",  {2'b00, bus.mem_addr_o}, 32'h044);
    check("t2_wdata", bus.mem_wdata_o, 32'h12345678);
    tick();
    tick();
    check("t2_data_bn",  {31'd0, bus.data_blocking_n_o}, 32'd1);
    check("t2_instr_bn", {31'd0, bus.instr_blocking_n_o}, 32'd0);
    bus.data_req_i = 1'b0; bus.data_we_i = 4'b0000;
    tick();
    check("t2_idle_req", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
    check("t2_i_addr", {2'b00, bus.mem_addr_o}, 32'h080);
    check("t2_i_we",   {28'd0, bus.mem_we_o}, 32'h0);
    tick();
    tick();
    check("t2_i_bn",    {31'd0, bus.instr_blocking_n_o}, 32'd1);
    check("t2_i_rdata", bus.instr_rdata_o, 32'h5A5A5ADA);
    bus.instr_req_i = 1'b0;
    tick();

    // 3: starvation limit 2 -> grants D, D, I, then D again (streak cleared)
    mem_lat = 1;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 30'h0C0;
    bus.data_req_i = 1'b1; bus.data_addr_i = 30'h0D0;
    tick(); check("t3_g1", {2'b00, bus.mem_addr_o}, 32'h0D0);
    tick(); check("t3_d1_bn", {31'd0, bus.data_blocking_n_o}, 32'd1);
    tick();
    tick(); check("t3_g2", {2'b00, bus.mem_addr_o}, 32'h0D0);
    tick();
    tick();
    tick(); check("t3_g3", {2'b00, bus.mem_addr_o}, 32'h0C0);
    tick(); check("t3_i_bn", {31'd0, bus.instr_blocking_n_o}, 32'd1);
    tick();
    tick(); check("t3_g4", {2'b00, bus.mem_addr_o}, 32'h0D0);
    tick(); check("t3_d4_bn", {31'd0, bus.data_blocking_n_o}, 32'd1);
    bus.data_req_i = 1'b0;
    tick();
    tick(); check("t3_g5", {2'b00, bus.mem_addr_o}, 32'h0C0);
    tick(); check("t3_i5_bn", {31'd0, bus.instr_blocking_n_o}, 32'd1);
    bus.instr_req_i = 1'b0;
    tick();

    // 4: fetch 0x100 redirected to 0x200 while busy
    mem_lat = 4;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 30'h100;
    tick(); check("t4_addr1", {2'b00, bus.mem_addr_o}, 32'h100);
    tick(); bus.instr_addr_i = 30'h200;
    tick();
    tick();
    tick(); check("t4_no_pulse", {31'd0, bus.instr_blocking_n_o}, 32'd0);
    tick();
    tick(); check("t4_addr2", {2'b00, bus.mem_addr_o}, 32'h200);
    tick();
    tick();
    tick();
    tick();
    check("t4_bn",    {31'd0, bus.instr_blocking_n_o}, 32'd1);
    check("t4_rdata", bus.instr_rdata_o, 32'h5A5A585A);
    bus.instr_req_i = 1'b0;
    tick();

    // 5: timeout after 8 busy cycles
    mem_lat = 0;
    bus.data_req_i = 1'b1; bus.data_addr_i = 30'h0E0;
    for (int c = 1; c <= TMO; c++) begin
      tick();
      check("t5_req_held", {31'd0, bus.mem_req_o}, 32'd1);
    end
    tick();
    check("t5_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
    check("t5_err",      {31'd0, bus.bus_err_o}, 32'd1);
    check("t5_bn",       {31'd0, bus.data_blocking_n_o}, 32'd1);
    check("t5_rdata",    bus.data_rdata_o, 32'd0);
    bus.data_req_i = 1'b0;
    tick();
    check("t5_err_sticky", {31'd0, bus.bus_err_o}, 32'd1);

    // 6: asynchronous reset in the middle of a data access
    bus.data_req_i = 1'b1; bus.data_addr_i = 30'h0F0;
    tick(); check("t6_busy", {31'd0, bus.mem_req_o}, 32'd1);
    tick();
    #1 rst_i = 1'b1;
    #1;
    check("t6_req_async", {31'd0, bus.mem_req_o}, 32'd0);
    check("t6_err_clr",   {31'd0, bus.bus_err_o}, 32'd0);
    check("t6_addr_clr",  {2'b00, bus.mem_addr_o}, 32'd0);
    check("t6_bn",        {31'd0, bus.data_blocking_n_o}, 32'd0);
    bus.data_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    tick();
    check("t6_late_rdy_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("t6_late_rdy_rd",  bus.data_rdata_o, 32'd0);
    mem_lat = 2;
    bus.data_req_i = 1'b1; bus.data_addr_i = 30'h0F4;
    tick(); check("t6_reissue", {2'b00, bus.mem_addr_o}, 32'h0F4);
    tick();
    tick(); check("t6_done_bn", {31'd0, bus.data_blocking_n_o}, 32'd1);
    bus.data_req_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
